// File: rtl/lc3_control_fsm_if.sv
// rtl/lc3_control_fsm_if.sv - LC-3 controller to datapath/memory signal bundle
interface lc3_control_fsm_if #(
    parameter int COUNT_W = 16
);
    logic [15:0]        ir;
    logic               n;
    logic               z;
    logic               p;
    logic               mem_ready;
    logic [1:0]         alu_control;
    logic               ld_pc;
    logic               ld_ir;
    logic               ld_mar;
    logic               ld_mdr;
    logic               ld_reg;
    logic               ld_cc;
    logic               gate_pc;
    logic               gate_alu;
    logic               gate_mdr;
    logic               gate_marmux;
    logic [1:0]         pcmux_sel;
    logic               addr1_sel;
    logic [1:0]         addr2_sel;
    logic               dr_sel;
    logic               sr1_sel;
    logic               mdr_sel;
    logic               mem_en;
    logic               mem_we;
    logic               halted;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  ir, n, z, p, mem_ready,
        output alu_control, ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc,
               gate_pc, gate_alu, gate_mdr, gate_marmux,
               pcmux_sel, addr1_sel, addr2_sel, dr_sel, sr1_sel, mdr_sel,
               mem_en, mem_we, halted, instr_count
    );

    modport slave (
        output ir, n, z, p, mem_ready,
        input  alu_control, ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc,
               gate_pc, gate_alu, gate_mdr, gate_marmux,
               pcmux_sel, addr1_sel, addr2_sel, dr_sel, sr1_sel, mdr_sel,
               mem_en, mem_we, halted, instr_count
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - multicycle LC-3 sequencer with retired-instruction counter
module lc3_control_fsm #(
    parameter int COUNT_W   = 16,
    parameter bit CC_ON_LEA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    lc3_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, IF_RD, IR_LD, DECODE, ALU, BR, JMP, JSR,
        LEA, ADDR, RD, WB, STD, WR, HALT
    } state_t;

    state_t             state;
    state_t             nextState;
    logic               retire;
    logic [3:0]         opcode;
    logic [COUNT_W-1:0] instrCount;

    assign opcode          = bus.ir[15:12];
    assign bus.instr_count = instrCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            instrCount <= '0;
        end else begin
            state <= nextState;
            if (retire) begin
                instrCount <= instrCount + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        nextState       = state;
        retire          = 1'b0;
        bus.alu_control = 2'b00;
        bus.ld_pc       = 1'b0;
        bus.ld_ir       = 1'b0;
        bus.ld_mar      = 1'b0;
        bus.ld_mdr      = 1'b0;
        bus.ld_reg      = 1'b0;
        bus.ld_cc       = 1'b0;
        bus.gate_pc     = 1'b0;
        bus.gate_alu    = 1'b0;
        bus.gate_mdr    = 1'b0;
        bus.gate_marmux = 1'b0;
        bus.pcmux_sel   = 2'b00;
        bus.addr1_sel   = 1'b0;
        bus.addr2_sel   = 2'b00;
        bus.dr_sel      = 1'b0;
        bus.sr1_sel     = 1'b0;
        bus.mdr_sel     = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.halted      = 1'b0;

        case (state)
            FETCH: begin
                bus.gate_pc = 1'b1;
                bus.ld_mar  = 1'b1;
                bus.ld_pc   = 1'b1;
                nextState   = IF_RD;
            end
            IF_RD, RD: begin
                bus.mem_en = 1'b1;
                if (bus.mem_ready) begin
                    bus.ld_mdr  = 1'b1;
                    bus.mdr_sel = 1'b1;
                    nextState   = (state == IF_RD) ? IR_LD : WB;
                end
            end
            IR_LD: begin
                bus.gate_mdr = 1'b1;
                bus.ld_ir    = 1'b1;
                nextState    = DECODE;
            end
            DECODE: begin
                case (opcode)
                    4'b0001, 4'b0101, 4'b1001:          nextState = ALU;
                    4'b0000:                            nextState = BR;
                    4'b1100:                            nextState = JMP;
                    4'b0100:                            nextState = JSR;
                    4'b0010, 4'b0110, 4'b0011, 4'b0111: nextState = ADDR;
                    4'b1110:                            nextState = LEA;
                    default:                            nextState = HALT;
                endcase
            end
            ALU: begin
                bus.gate_alu    = 1'b1;
                bus.ld_reg      = 1'b1;
                bus.ld_cc       = 1'b1;
                bus.alu_control = (opcode == 4'b0001) ? 2'b01 :
                                  (opcode == 4'b0101) ? 2'b10 : 2'b11;
                retire          = 1'b1;
                nextState       = FETCH;
            end
            BR: begin
                if ((bus.ir[11] & bus.n) | (bus.ir[10] & bus.z) | (bus.ir[9] & bus.p)) begin
                    bus.ld_pc     = 1'b1;
                    bus.pcmux_sel = 2'b10;
                    bus.addr2_sel = 2'b10;
                end
                retire    = 1'b1;
                nextState = FETCH;
            end
            JMP: begin
                bus.ld_pc     = 1'b1;
                bus.pcmux_sel = 2'b10;
                bus.addr1_sel = 1'b1;
                retire        = 1'b1;
                nextState     = FETCH;
            end
            JSR: begin
                // R7 takes the old PC off the bus on the same edge the PC reloads
                bus.gate_pc   = 1'b1;
                bus.ld_reg    = 1'b1;
                bus.dr_sel    = 1'b1;
                bus.ld_pc     = 1'b1;
                bus.pcmux_sel = 2'b10;
                if (bus.ir[11]) begin
                    bus.addr2_sel = 2'b11;
                end else begin
                    bus.addr1_sel = 1'b1;
                end
                retire    = 1'b1;
                nextState = FETCH;
            end
            LEA: begin
                bus.gate_marmux = 1'b1;
                bus.ld_reg      = 1'b1;
                bus.addr2_sel   = 2'b10;
                bus.ld_cc       = CC_ON_LEA;
                retire          = 1'b1;
                nextState       = FETCH;
            end
            ADDR: begin
                // opcode[2] picks base+offset6, opcode[0] marks a store
                bus.gate_marmux = 1'b1;
                bus.ld_mar      = 1'b1;
                if (opcode[2]) begin
                    bus.addr1_sel = 1'b1;
                    bus.addr2_sel = 2'b01;
                end else begin
                    bus.addr2_sel = 2'b10;
                end
                nextState = opcode[0] ? STD : RD;
            end
            WB: begin
                bus.gate_mdr = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
                retire       = 1'b1;
                nextState    = FETCH;
            end
            STD: begin
                bus.sr1_sel  = 1'b1;
                bus.gate_alu = 1'b1;
                bus.ld_mdr   = 1'b1;
                nextState    = WR;
            end
            WR: begin
                bus.mem_en = 1'b1;
                bus.mem_we = 1'b1;
                if (bus.mem_ready) begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: nextState = FETCH;
        endcase
    end
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb/tb_lc3_control_fsm.sv - directed table, random instruction stream and reset checks
module tb_lc3_control_fsm;
    localparam int CW     = 4;
    localparam bit CC_LEA = 1'b0;

    localparam logic [22:0] ALU_ADD  = 23'd1 << 21;
    localparam logic [22:0] ALU_AND  = 23'd2 << 21;
    localparam logic [22:0] ALU_NOT  = 23'd3 << 21;
    localparam logic [22:0] LD_PC    = 23'd1 << 20;
    localparam logic [22:0] LD_IR    = 23'd1 << 19;
    localparam logic [22:0] LD_MAR   = 23'd1 << 18;
    localparam logic [22:0] LD_MDR   = 23'd1 << 17;
    localparam logic [22:0] LD_REG   = 23'd1 << 16;
    localparam logic [22:0] LD_CC    = 23'd1 << 15;
    localparam logic [22:0] G_PC     = 23'd1 << 14;
    localparam logic [22:0] G_ALU    = 23'd1 << 13;
    localparam logic [22:0] G_MDR    = 23'd1 << 12;
    localparam logic [22:0] G_MARMUX = 23'd1 << 11;
    localparam logic [22:0] PCM_ADD  = 23'd2 << 9;
    localparam logic [22:0] A1_BASE  = 23'd1 << 8;
    localparam logic [22:0] A2_OFF6  = 23'd1 << 6;
    localparam logic [22:0] A2_OFF9  = 23'd2 << 6;
    localparam logic [22:0] A2_OFF11 = 23'd3 << 6;
    localparam logic [22:0] DR_R7    = 23'd1 << 5;
    localparam logic [22:0] SR1_HI   = 23'd1 << 4;
    localparam logic [22:0] MDR_MEM  = 23'd1 << 3;
    localparam logic [22:0] MEM_EN   = 23'd1 << 2;
    localparam logic [22:0] MEM_WE   = 23'd1 << 1;
    localparam logic [22:0] HALTED   = 23'd1;
    localparam logic [22:0] FETCH_V  = G_PC | LD_MAR | LD_PC;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  nzp;
        int          wF;
        int          wM;
        logic [22:0] key;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lc3_control_fsm_if #(.COUNT_W(CW)) bus();
    lc3_control_fsm #(.COUNT_W(CW), .CC_ON_LEA(CC_LEA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [22:0] dutOut;
    assign dutOut = {bus.alu_control, bus.ld_pc, bus.ld_ir, bus.ld_mar, bus.ld_mdr, bus.ld_reg,
                     bus.ld_cc, bus.gate_pc, bus.gate_alu, bus.gate_mdr, bus.gate_marmux,
                     bus.pcmux_sel, bus.addr1_sel, bus.addr2_sel, bus.dr_sel, bus.sr1_sel,
                     bus.mdr_sel, bus.mem_en, bus.mem_we, bus.halted};

    int          total = 0;
    int          bad = 0;
    logic [CW-1:0] expCount;
    logic [22:0] expQ[$];
    bit          mrQ[$];
    vec_t        tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [22:0] v, input bit mr);
        expQ.push_back(v);
        mrQ.push_back(mr);
    endtask

    // Expected per-cycle output trace of one instruction, built from its opcode class.
    task automatic runInstr(input logic [15:0] irv, input logic [2:0] nzp, input int wF,
                            input int wM, input bit useKey, input logic [22:0] key,
                            input string tag);
        logic [3:0] op;
        logic [22:0] ex;
        bit isHalt;
        op = irv[15:12];
        isHalt = 1'b0;
        expQ.delete();
        mrQ.delete();
        push(FETCH_V, 1'($urandom));
        for (int i = 0; i < wF; i++) push(MEM_EN, 1'b0);
        push(MEM_EN | LD_MDR | MDR_MEM, 1'b1);
        push(G_MDR | LD_IR, 1'($urandom));
        push(23'd0, 1'($urandom));
        if (op == 4'd1 || op == 4'd5 || op == 4'd9) begin
            ex = (op == 4'd1) ? ALU_ADD : (op == 4'd5) ? ALU_AND : ALU_NOT;
            push(ex | G_ALU | LD_REG | LD_CC, 1'($urandom));
        end else if (op == 4'd0) begin
            if ((irv[11] && nzp[2]) || (irv[10] && nzp[1]) || (irv[9] && nzp[0]))
                push(LD_PC | PCM_ADD | A2_OFF9, 1'($urandom));
            else
                push(23'd0, 1'($urandom));
        end else if (op == 4'd12) begin
            push(LD_PC | PCM_ADD | A1_BASE, 1'($urandom));
        end else if (op == 4'd4) begin
            ex = G_PC | LD_REG | DR_R7 | LD_PC | PCM_ADD;
            push(irv[11] ? (ex | A2_OFF11) : (ex | A1_BASE), 1'($urandom));
        end else if (op == 4'd14) begin
            push(G_MARMUX | LD_REG | A2_OFF9 | (CC_LEA ? LD_CC : 23'd0), 1'($urandom));
        end else if (op == 4'd2 || op == 4'd3) begin
            push(G_MARMUX | LD_MAR | A2_OFF9, 1'($urandom));
        end else if (op == 4'd6 || op == 4'd7) begin
            push(G_MARMUX | LD_MAR | A1_BASE | A2_OFF6, 1'($urandom));
        end else begin
            isHalt = 1'b1;
            for (int i = 0; i < 4; i++) push(HALTED, 1'($urandom));
        end
        if (op == 4'd2 || op == 4'd6) begin
            for (int i = 0; i < wM; i++) push(MEM_EN, 1'b0);
            push(MEM_EN | LD_MDR | MDR_MEM, 1'b1);
            push(G_MDR | LD_REG | LD_CC, 1'($urandom));
        end else if (op == 4'd3 || op == 4'd7) begin
            push(SR1_HI | G_ALU | LD_MDR, 1'($urandom));
            for (int i = 0; i < wM; i++) push(MEM_EN | MEM_WE, 1'b0);
            push(MEM_EN | MEM_WE, 1'b1);
        end

        bus.ir = irv;
        {bus.n, bus.z, bus.p} = nzp;
        for (int i = 0; i < expQ.size(); i++) begin
            bus.mem_ready = mrQ[i];
            @(negedge clk);
            check($sformatf("%s_c%0d_out", tag, i), 32'(dutOut), 32'(expQ[i]));
            check($sformatf("%s_c%0d_cnt", tag, i), 32'(bus.instr_count), 32'(expCount));
            check($sformatf("%s_c%0d_gates", tag, i), 32'($countones(dutOut[14:11]) <= 1), 32'd1);
            if (useKey && i == expQ.size() - 1)
                check($sformatf("%s_key", tag), 32'(dutOut), 32'(key));
            @(posedge clk);
            #1;
        end
        if (isHalt) begin
            rst_n = 1'b0;
            #1;
            check($sformatf("%s_halt_rst", tag), 32'(dutOut), 32'(FETCH_V));
            rst_n = 1'b1;
            expCount = '0;
        end else begin
            expCount = expCount + 1'b1;
        end
    endtask

    initial begin
        logic [15:0] r;
        logic [3:0]  op;
        tbl.push_back('{16'h1262, 3'b000, 0, 0, ALU_ADD | G_ALU | LD_REG | LD_CC});
        tbl.push_back('{16'h0402, 3'b010, 0, 0, LD_PC | PCM_ADD | A2_OFF9});
        tbl.push_back('{16'h0402, 3'b100, 0, 0, 23'd0});
        tbl.push_back('{16'h2205, 3'b001, 0, 3, G_MDR | LD_REG | LD_CC});
        tbl.push_back('{16'h7281, 3'b000, 1, 2, MEM_EN | MEM_WE});
        tbl.push_back('{16'h4805, 3'b000, 0, 0, G_PC | LD_REG | DR_R7 | LD_PC | PCM_ADD | A2_OFF11});
        tbl.push_back('{16'h4080, 3'b000, 0, 0, G_PC | LD_REG | DR_R7 | LD_PC | PCM_ADD | A1_BASE});
        tbl.push_back('{16'hC080, 3'b000, 2, 0, LD_PC | PCM_ADD | A1_BASE});
        tbl.push_back('{16'hE3FF, 3'b000, 0, 0, G_MARMUX | LD_REG | A2_OFF9});
        tbl.push_back('{16'h5042, 3'b000, 0, 0, ALU_AND | G_ALU | LD_REG | LD_CC});
        tbl.push_back('{16'h967F, 3'b000, 0, 0, ALU_NOT | G_ALU | LD_REG | LD_CC});
        tbl.push_back('{16'h3405, 3'b000, 0, 1, MEM_EN | MEM_WE});
        tbl.push_back('{16'h6283, 3'b000, 2, 0, G_MDR | LD_REG | LD_CC});
        tbl.push_back('{16'hF025, 3'b000, 0, 0, HALTED});

        rst_n = 1'b0;
        bus.ir = 16'h0;
        {bus.n, bus.z, bus.p} = 3'b000;
        bus.mem_ready = 1'b0;
        expCount = '0;
        @(negedge clk);
        check("reset_out", 32'(dutOut), 32'(FETCH_V));
        check("reset_cnt", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            runInstr(tbl[i].ir, tbl[i].nzp, tbl[i].wF, tbl[i].wM, 1'b1, tbl[i].key,
                     $sformatf("v%0d", i));

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            if ((op == 4'd8 || op == 4'd10 || op == 4'd11 || op == 4'd13 || op == 4'd15)
                && ($urandom_range(0, 3) != 0))
                op = 4'd1;
            r = 16'($urandom);
            r[15:12] = op;
            runInstr(r, 3'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     1'b0, 23'd0, $sformatf("r%0d", k));
        end

        if (expCount == '0)
            runInstr(16'h1262, 3'b000, 0, 0, 1'b0, 23'd0, "pre");

        // Store stalled in WR, then an asynchronous reset between clock edges
        bus.ir = 16'h3405;
        bus.mem_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("wr_mem", 32'(dutOut[2:1]), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mem_drop", 32'(dutOut[2:1]), 32'd0);
        check("rst_cnt", 32'(bus.instr_count), 32'd0);
        check("rst_out", 32'(dutOut), 32'(FETCH_V));
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ifrd", 32'(dutOut), 32'(MEM_EN));
        check("post_rst_cnt", 32'(bus.instr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
